// File: rtl/bird_launch_move.sv
// Slingshot bird motion: READY -> FLY (ballistic, pixel*64 fixed point) -> STOP -> respawn.
// Optional bounce-on-collision behaviour is enabled by defining BIRD_BOUNCE_EN.
module bird_launch_move #(
  parameter int INITIAL_X      = 64,
  parameter int INITIAL_Y      = 380,
  parameter int LAUNCH_VX      = 200,
  parameter int LAUNCH_VY      = -400,
  parameter int GRAVITY        = 8,
  parameter int X_MAX          = 640,
  parameter int Y_MAX          = 480,
  parameter int RESPAWN_FRAMES = 30
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               shoot,
  input  logic               startOfFrame,
  input  logic               collision,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               bird_flying,
  output logic               bird_done
);

  typedef enum logic [1:0] {
    READY_ST = 2'd0,
    FLY_ST   = 2'd1,
    STOP_ST  = 2'd2
  } state_t;

  localparam logic signed [31:0] INIT_X_FP = 32'(INITIAL_X * 64);
  localparam logic signed [31:0] INIT_Y_FP = 32'(INITIAL_Y * 64);

  state_t             state_q, state_d;
  logic signed [31:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [15:0] vx_q, vx_d, vy_q, vy_d;
  logic               flag_q, flag_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               bird_flying_q, bird_done_q;
  logic               bird_done_d;

  logic signed [31:0] nx_s, ny_s;
  logic signed [25:0] npx_s, npy_s;
  logic               hit_s, oob_s, bounce_ok_s, respawn_s;

`ifdef BIRD_BOUNCE_EN
  logic [1:0] bounce_q, bounce_d;
`endif

  // Candidate motion update and the checks evaluated against it at a frame tick
  always_comb begin
    nx_s      = pos_x_q + 32'(vx_q);
    ny_s      = pos_y_q + 32'(vy_q);
    npx_s     = nx_s[31:6];
    npy_s     = ny_s[31:6];
    oob_s     = (npx_s > $signed(26'(X_MAX))) || nx_s[31] || (npy_s > $signed(26'(Y_MAX)));
    hit_s     = flag_q || collision;
    respawn_s = (cnt_q == 16'(RESPAWN_FRAMES - 1));
`ifdef BIRD_BOUNCE_EN
    bounce_ok_s = (vy_q > 16'sd0) && (bounce_q < 2'd2);
`else
    bounce_ok_s = 1'b0;
`endif
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q       <= READY_ST;
      pos_x_q       <= INIT_X_FP;
      pos_y_q       <= INIT_Y_FP;
      vx_q          <= 16'sd0;
      vy_q          <= 16'sd0;
      flag_q        <= 1'b0;
      cnt_q         <= 16'd0;
      bird_flying_q <= 1'b0;
      bird_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      vx_q          <= vx_d;
      vy_q          <= vy_d;
      flag_q        <= flag_d;
      cnt_q         <= cnt_d;
      bird_flying_q <= (state_q == FLY_ST);
      bird_done_q   <= bird_done_d;
    end
  end

`ifdef BIRD_BOUNCE_EN
  // Bounce counter register
  always_ff @(posedge clk) begin
    if (!resetN) begin
      bounce_q <= 2'd0;
    end else begin
      bounce_q <= bounce_d;
    end
  end
`endif

  // Next-state logic; a flagged collision outranks an out-of-bounds result
  always_comb begin
    state_d = state_q;
    case (state_q)
      READY_ST: begin
        if (shoot) state_d = FLY_ST;
        else       state_d = READY_ST;
      end
      FLY_ST: begin
        if (startOfFrame && hit_s && !bounce_ok_s) state_d = STOP_ST;
        else if (startOfFrame && !hit_s && oob_s)  state_d = STOP_ST;
        else                                       state_d = FLY_ST;
      end
      STOP_ST: begin
        if (startOfFrame && respawn_s) state_d = READY_ST;
        else                           state_d = STOP_ST;
      end
      default: state_d = READY_ST;
    endcase
  end

  // Datapath next values per state
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    flag_d  = 1'b0;
    cnt_d   = cnt_q;
`ifdef BIRD_BOUNCE_EN
    bounce_d = bounce_q;
`endif
    case (state_q)
      READY_ST: begin
        pos_x_d = INIT_X_FP;
        pos_y_d = INIT_Y_FP;
        cnt_d   = 16'd0;
`ifdef BIRD_BOUNCE_EN
        bounce_d = 2'd0;
`endif
        if (shoot) begin
          vx_d = 16'(LAUNCH_VX);
          vy_d = 16'(LAUNCH_VY);
        end else begin
          vx_d = 16'sd0;
          vy_d = 16'sd0;
        end
      end
      FLY_ST: begin
        if (!startOfFrame) begin
          flag_d = hit_s;
        end else if (hit_s && bounce_ok_s) begin
          vy_d = -(vy_q >>> 1);
`ifdef BIRD_BOUNCE_EN
          bounce_d = bounce_q + 2'd1;
`endif
        end else if (hit_s) begin
          vx_d = 16'sd0;
          vy_d = 16'sd0;
        end else begin
          pos_x_d = nx_s;
          pos_y_d = ny_s;
          vy_d    = vy_q + 16'(GRAVITY);
        end
      end
      STOP_ST: begin
        if (startOfFrame && respawn_s) begin
          cnt_d   = 16'd0;
          pos_x_d = INIT_X_FP;
          pos_y_d = INIT_Y_FP;
        end else if (startOfFrame) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        pos_x_d = INIT_X_FP;
        pos_y_d = INIT_Y_FP;
      end
    endcase
  end

  // Output decode
  always_comb begin
    bird_done_d = (state_q == STOP_ST) && (state_d == READY_ST);
  end

  assign topLeftX    = pos_x_q[16:6];
  assign topLeftY    = pos_y_q[16:6];
  assign bird_flying = bird_flying_q;
  assign bird_done   = bird_done_q;

endmodule

// File: tb/tb_bird_launch_move.sv
// Directed self-checking bench for bird_launch_move; bounce scenario runs when BIRD_BOUNCE_EN is defined.
module tb_bird_launch_move;
  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               shoot = 1'b0;
  logic               startOfFrame = 1'b0;
  logic               collision = 1'b0;
  logic signed [10:0] topLeftX, topLeftY;
  logic               bird_flying, bird_done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  bird_launch_move dut (
    .clk(clk), .resetN(resetN), .shoot(shoot), .startOfFrame(startOfFrame),
    .collision(collision), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .bird_flying(bird_flying), .bird_done(bird_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bird_done) done_cnt++;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    cyc(1);
    startOfFrame = 1'b0;
    cyc(2);
  endtask

  task automatic do_shoot();
    shoot = 1'b1;
    cyc(1);
    shoot = 1'b0;
    cyc(2);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    cyc(2);
    resetN = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (topLeftX !== 11'sd64)  begin n_fail++; $display("FAIL reset_x got %0d want 64", topLeftX); end
    n_checks++; if (topLeftY !== 11'sd380) begin n_fail++; $display("FAIL reset_y got %0d want 380", topLeftY); end
    n_checks++; if (bird_flying !== 1'b0)  begin n_fail++; $display("FAIL reset_flying got %b want 0", bird_flying); end
    n_checks++; if (bird_done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %b want 0", bird_done); end
    frame();
    n_checks++; if (topLeftX !== 11'sd64 || bird_flying !== 1'b0) begin n_fail++; $display("FAIL ready_hold x=%0d fly=%b want 64/0", topLeftX, bird_flying); end
  endtask

  task automatic test_first_frame();
    do_shoot();
    n_checks++; if (bird_flying !== 1'b1) begin n_fail++; $display("FAIL shoot_flying got %b want 1", bird_flying); end
    n_checks++; if (topLeftX !== 11'sd64 || topLeftY !== 11'sd380) begin n_fail++; $display("FAIL shoot_pos got %0d/%0d want 64/380", topLeftX, topLeftY); end
    frame();
    n_checks++; if (topLeftX !== 11'sd67)  begin n_fail++; $display("FAIL frame1_x got %0d want 67", topLeftX); end
    n_checks++; if (topLeftY !== 11'sd373) begin n_fail++; $display("FAIL frame1_y got %0d want 373", topLeftY); end
    n_checks++; if (dut.vy_q !== -16'sd392) begin n_fail++; $display("FAIL frame1_vy got %0d want -392", dut.vy_q); end
    n_checks++; if (bird_flying !== 1'b1) begin n_fail++; $display("FAIL frame1_flying got %b want 1", bird_flying); end
  endtask

  task automatic test_collision();
    collision = 1'b1;
    cyc(1);
    collision = 1'b0;
    cyc(2);
    frame();
    n_checks++; if (topLeftX !== 11'sd67 || topLeftY !== 11'sd373) begin n_fail++; $display("FAIL coll_pos got %0d/%0d want 67/373", topLeftX, topLeftY); end
    n_checks++; if (bird_flying !== 1'b0) begin n_fail++; $display("FAIL coll_stop flying=%b want 0", bird_flying); end
    done_cnt = 0;
    repeat (29) frame();
    n_checks++; if (done_cnt !== 0 || topLeftX !== 11'sd67) begin n_fail++; $display("FAIL stop_hold done=%0d x=%0d want 0/67", done_cnt, topLeftX); end
    frame();
    cyc(3);
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL done_pulse count=%0d want 1", done_cnt); end
    n_checks++; if (topLeftX !== 11'sd64 || topLeftY !== 11'sd380) begin n_fail++; $display("FAIL respawn_pos got %0d/%0d want 64/380", topLeftX, topLeftY); end
  endtask

  task automatic test_free_flight();
    int mx, my, mvy, stop_frame;
    bit exp_stop;
    mx = 64 * 64; my = 380 * 64; mvy = -400; stop_frame = -1;
    do_shoot();
    for (int f = 1; f <= 200 && stop_frame < 0; f++) begin
      shoot = 1'b1;
      cyc(1);
      shoot = 1'b0;
      frame();
      mx += 200; my += mvy; mvy += 8;
      exp_stop = ((mx >>> 6) > 640) || (mx < 0) || ((my >>> 6) > 480);
      n_checks++;
      if (int'(topLeftX) !== (mx >>> 6) || int'(topLeftY) !== (my >>> 6)) begin
        n_fail++; $display("FAIL flight_pos frame %0d got %0d/%0d want %0d/%0d", f, topLeftX, topLeftY, mx >>> 6, my >>> 6);
      end
      n_checks++;
      if (bird_flying !== !exp_stop) begin
        n_fail++; $display("FAIL flight_state frame %0d flying=%b want %b", f, bird_flying, !exp_stop);
      end
      if (!bird_flying) stop_frame = f;
    end
    n_checks++; if (stop_frame !== 116) begin n_fail++; $display("FAIL stop_frame got %0d want 116", stop_frame); end
    n_checks++; if (topLeftY !== 11'sd488 || topLeftX !== 11'sd426) begin n_fail++; $display("FAIL stop_pos got %0d/%0d want 426/488", topLeftX, topLeftY); end
    repeat (30) frame();
    n_checks++; if (topLeftY !== 11'sd380 || bird_flying !== 1'b0) begin n_fail++; $display("FAIL rearm y=%0d fly=%b want 380/0", topLeftY, bird_flying); end
  endtask

  task automatic test_shoot_sof();
    shoot = 1'b1;
    startOfFrame = 1'b1;
    cyc(1);
    shoot = 1'b0;
    startOfFrame = 1'b0;
    cyc(2);
    n_checks++; if (bird_flying !== 1'b1) begin n_fail++; $display("FAIL coinc_flying got %b want 1", bird_flying); end
    n_checks++; if (topLeftX !== 11'sd64 || topLeftY !== 11'sd380) begin n_fail++; $display("FAIL coinc_pos got %0d/%0d want 64/380", topLeftX, topLeftY); end
    frame();
    n_checks++; if (topLeftX !== 11'sd67 || topLeftY !== 11'sd373) begin n_fail++; $display("FAIL coinc_next got %0d/%0d want 67/373", topLeftX, topLeftY); end
  endtask

  task automatic test_reset_mid_flight();
    frame();
    resetN = 1'b0;
    cyc(1);
    resetN = 1'b1;
    n_checks++; if (topLeftX !== 11'sd64 || topLeftY !== 11'sd380) begin n_fail++; $display("FAIL midrst_pos got %0d/%0d want 64/380", topLeftX, topLeftY); end
    n_checks++; if (bird_flying !== 1'b0) begin n_fail++; $display("FAIL midrst_flying got %b want 0", bird_flying); end
    frame();
    n_checks++; if (topLeftX !== 11'sd64 || bird_flying !== 1'b0) begin n_fail++; $display("FAIL midrst_ready x=%0d fly=%b want 64/0", topLeftX, bird_flying); end
  endtask

`ifdef BIRD_BOUNCE_EN
  task automatic hit_frame();
    collision = 1'b1;
    cyc(1);
    collision = 1'b0;
    frame();
  endtask

  task automatic test_bounce();
    do_reset();
    do_shoot();
    repeat (75) frame();
    n_checks++; if (dut.vy_q !== 16'sd200) begin n_fail++; $display("FAIL bounce_pre vy=%0d want 200", dut.vy_q); end
    hit_frame();
    n_checks++; if (dut.vy_q !== -16'sd100 || bird_flying !== 1'b1) begin n_fail++; $display("FAIL bounce1 vy=%0d fly=%b want -100/1", dut.vy_q, bird_flying); end
    repeat (13) frame();
    hit_frame();
    n_checks++; if (dut.vy_q !== -16'sd2 || bird_flying !== 1'b1) begin n_fail++; $display("FAIL bounce2 vy=%0d fly=%b want -2/1", dut.vy_q, bird_flying); end
    frame();
    hit_frame();
    n_checks++; if (bird_flying !== 1'b0) begin n_fail++; $display("FAIL bounce3_stop fly=%b want 0", bird_flying); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_frame();
    test_collision();
    test_free_flight();
    test_shoot_sof();
    test_reset_mid_flight();
`ifdef BIRD_BOUNCE_EN
    test_bounce();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
